// File: rtl/mnist_classify_seq_if.sv
// Handshake/bus bundle for mnist_classify_seq.
// Groups the request, fetcher and result channels; clock and reset stay outside.
// slave  : the sequencer itself.
// master : the surroundings (requester, fetcher, bias ROM, result consumer).
// Build option: MNIST_CLS_TOP2_EN adds res_class2 / res_margin.
interface mnist_classify_seq_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IMAGES      = 10
);
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int IW = (IMAGES > 1) ? $clog2(IMAGES) : 1;
  localparam int SW = 2 * DATA_WIDTH;

  logic                            req_valid;
  logic [IW-1:0]                   req_img;
  logic                            req_ready;
  logic [IW-1:0]                   img_sel;
  logic                            comp_start;
  logic                            comp_ready;
  logic [NUM_CLASSES*SW-1:0]       scores;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] bias;
  logic                            res_valid;
  logic                            res_ready;
  logic [CW-1:0]                   res_class;
  logic [SW-1:0]                   res_score;
  logic                            busy;
  logic                            err_timeout;
`ifdef MNIST_CLS_TOP2_EN
  logic [CW-1:0]                   res_class2;
  logic [SW-1:0]                   res_margin;
`endif

  modport slave (
    input  req_valid, req_img, comp_ready, scores, bias, res_ready,
    output req_ready, img_sel, comp_start, res_valid, res_class, res_score,
           busy, err_timeout
`ifdef MNIST_CLS_TOP2_EN
    , output res_class2, res_margin
`endif
  );

  modport master (
    output req_valid, req_img, comp_ready, scores, bias, res_ready,
    input  req_ready, img_sel, comp_start, res_valid, res_class, res_score,
           busy, err_timeout
`ifdef MNIST_CLS_TOP2_EN
    , input res_class2, res_margin
`endif
  );
endinterface

// File: rtl/mnist_classify_seq.sv
// MNIST classification sequencer.
// Accepts an image index, launches the systolic fetcher, captures the score
// row on a fresh rise of comp_ready while adding bias with saturation, then
// scans for the argmax one class per cycle and presents the result.
// Build option: MNIST_CLS_TOP2_EN also tracks the runner-up class and the
// saturated margin between best and runner-up scores.
module mnist_classify_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IMAGES      = 10,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mnist_classify_seq_if.slave  bus
);
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int IW = (IMAGES > 1) ? $clog2(IMAGES) : 1;
  localparam int SW = 2 * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_SCAN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]                   img_q;
  logic                            prev_rdy_q;
  logic [TW-1:0]                   tcnt_q;
  logic                            err_q;
  logic [NUM_CLASSES-1:0][SW-1:0]  sum_q;
  logic [NUM_CLASSES-1:0][SW-1:0]  sum_d;
  logic [SW-1:0]                   best_q;
  logic [CW-1:0]                   idx_q;
  logic [CW-1:0]                   scan_i_q;
  logic [SW-1:0]                   cur;
  logic                            rise;
  logic                            to_hit;
  logic                            scan_last;
  logic                            cur_gt_best;
`ifdef MNIST_CLS_TOP2_EN
  logic [SW-1:0]                   sec_q;
  logic [CW-1:0]                   idx2_q;
  logic                            have2_q;
  logic [SW:0]                     diff;
`endif

  // Per-class saturating bias add, evaluated combinationally and captured on the rise
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
    logic [SW:0] ext;
    assign ext = {bus.scores[g*SW+SW-1], bus.scores[g*SW +: SW]}
               + {{(SW-DATA_WIDTH+1){bus.bias[g*DATA_WIDTH+DATA_WIDTH-1]}},
                  bus.bias[g*DATA_WIDTH +: DATA_WIDTH]};
    // sign bits disagree only on overflow; the carry-out bit gives the direction
    assign sum_d[g] = (ext[SW] ^ ext[SW-1]) ? (ext[SW] ? SMIN : SMAX) : ext[SW-1:0];
  end

  // A level already high when launched is not a rise: prev_rdy_q tracks every cycle
  assign rise        = bus.comp_ready & ~prev_rdy_q;
  // Counter is cleared in LAUNCH; firing one count early makes the error visible
  // exactly TIMEOUT cycles after the launch pulse
  assign to_hit      = (tcnt_q == TW'(TIMEOUT - 2));
  assign cur         = sum_q[scan_i_q];
  assign scan_last   = (scan_i_q == CW'(NUM_CLASSES - 1));
  assign cur_gt_best = $signed(cur) > $signed(best_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (rise) state_d = S_SCAN;
                else if (to_hit) state_d = S_IDLE;
      S_SCAN:   if (scan_last) state_d = S_DONE;
      S_DONE:   if (bus.res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: image latch, timeout counter, score capture and serial argmax
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      img_q      <= '0;
      prev_rdy_q <= 1'b0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      sum_q      <= '0;
      best_q     <= '0;
      idx_q      <= '0;
      scan_i_q   <= '0;
`ifdef MNIST_CLS_TOP2_EN
      sec_q      <= '0;
      idx2_q     <= '0;
      have2_q    <= 1'b0;
`endif
    end else begin
      prev_rdy_q <= bus.comp_ready;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            img_q <= ({1'b0, bus.req_img} >= (IW+1)'(IMAGES)) ? IW'(IMAGES - 1) : bus.req_img;
            err_q <= 1'b0;
          end
        end
        S_LAUNCH: tcnt_q <= '0;
        S_WAIT: begin
          if (rise) begin
            sum_q    <= sum_d;
            best_q   <= sum_d[0];
            idx_q    <= '0;
            scan_i_q <= CW'(1);
`ifdef MNIST_CLS_TOP2_EN
            sec_q    <= '0;
            idx2_q   <= '0;
            have2_q  <= 1'b0;
`endif
          end else if (to_hit) begin
            err_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_SCAN: begin
          // strict compare keeps the lowest index on ties
          if (cur_gt_best) begin
            best_q <= cur;
            idx_q  <= scan_i_q;
`ifdef MNIST_CLS_TOP2_EN
            sec_q   <= best_q;
            idx2_q  <= idx_q;
            have2_q <= 1'b1;
`endif
          end
`ifdef MNIST_CLS_TOP2_EN
          else if (!have2_q || ($signed(cur) > $signed(sec_q))) begin
            // a tie with best lands here and becomes runner-up
            sec_q   <= cur;
            idx2_q  <= scan_i_q;
            have2_q <= 1'b1;
          end
`endif
          scan_i_q <= scan_i_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.comp_start  = (state_q == S_LAUNCH);
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.img_sel     = img_q;
  assign bus.res_class   = idx_q;
  assign bus.res_score   = best_q;
  assign bus.err_timeout = err_q;

`ifdef MNIST_CLS_TOP2_EN
  // best >= runner-up, so the difference is non-negative; clamp if it exceeds SMAX
  assign diff           = {best_q[SW-1], best_q} - {sec_q[SW-1], sec_q};
  assign bus.res_class2 = idx2_q;
  assign bus.res_margin = (diff[SW] | diff[SW-1]) ? SMAX : diff[SW-1:0];
`endif
endmodule

// File: tb/tb_mnist_classify_seq.sv
// Directed bench for mnist_classify_seq: table of image transactions plus
// hand-written sequences for level-high launch, reset mid-run and timeout.
module tb_mnist_classify_seq;
  localparam int DW = 16;
  localparam int NC = 10;
  localparam int IM = 10;
  localparam int SW = 2 * DW;
  localparam int CW = 4;
  localparam int IW = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mnist_classify_seq_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IMAGES(IM)) m ();
  mnist_classify_seq_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IMAGES(IM)) t ();

  mnist_classify_seq #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IMAGES(IM), .TIMEOUT(64)) u_dut (
    .clk(clk), .reset_n(rst_n), .bus(m)
  );
  mnist_classify_seq #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IMAGES(IM), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .reset_n(rst_n), .bus(t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0]    img;
    logic [NC*SW-1:0] sc;
    logic [NC*DW-1:0] bs;
    int               dly;
    int               hold;   // >0 backpressure cycles, -1 res_ready high from start
    logic [IW-1:0]    exp_sel;
    logic [CW-1:0]    exp_cls;
    logic [SW-1:0]    exp_scr;
    logic [CW-1:0]    exp_c2;
    logic [SW-1:0]    exp_mg;
  } vec_t;

  vec_t vt[7];

  function automatic logic [NC*SW-1:0] rep_s(input logic [SW-1:0] v);
    logic [NC*SW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*SW +: SW] = v;
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] rep_b(input logic [DW-1:0] v);
    logic [NC*DW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int k;
    @(negedge clk);
    m.scores    = vt[i].sc;
    m.bias      = vt[i].bs;
    m.req_img   = vt[i].img;
    m.req_valid = 1'b1;
    m.res_ready = (vt[i].hold < 0);
    chk("req_ready_idle", m.req_ready, 1);
    @(negedge clk);
    m.req_valid = 1'b0;
    chk("comp_start_pulse", m.comp_start, 1);
    chk("img_sel", m.img_sel, vt[i].exp_sel);
    chk("busy_launch", m.busy, 1);
    @(negedge clk);
    chk("comp_start_drop", m.comp_start, 0);
    repeat (vt[i].dly - 1) @(negedge clk);
    m.comp_ready = 1'b1;
    k = 0;
    while (!m.res_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("result_latency", k, NC);
    chk("res_class", m.res_class, vt[i].exp_cls);
    chk("res_score", m.res_score, vt[i].exp_scr);
`ifdef MNIST_CLS_TOP2_EN
    chk("res_class2", m.res_class2, vt[i].exp_c2);
    chk("res_margin", m.res_margin, vt[i].exp_mg);
`endif
    if (vt[i].hold > 0) begin
      // scores change and comp_ready toggles; result must not move
      m.scores = rep_s(32'h7FFF_0000);
      for (int h = 0; h < vt[i].hold; h++) begin
        m.comp_ready = ~m.comp_ready;
        @(negedge clk);
        chk("hold_valid", m.res_valid, 1);
        chk("hold_class", m.res_class, vt[i].exp_cls);
        chk("hold_score", m.res_score, vt[i].exp_scr);
        chk("hold_req_ready", m.req_ready, 0);
      end
    end
    m.res_ready = 1'b1;
    @(negedge clk);
    chk("res_valid_drop", m.res_valid, 0);
    chk("req_ready_back", m.req_ready, 1);
    m.res_ready  = 1'b0;
    m.comp_ready = 1'b0;
  endtask

  initial begin
    logic [NC*SW-1:0] s;
    logic [NC*DW-1:0] b;
    int nv;
    int k;
    n_cmp = 0;
    n_err = 0;

    // class 7 wins, long fetch, backpressure
    s = rep_s(32'd100); s[7*SW +: SW] = 32'd500; b = rep_b('0);
    vt[0] = '{4'd3, s, b, 20, 10, 4'd3, 4'd7, 32'd500, 4'd0, 32'd400};
    // tie 2/5 keeps lowest, out-of-range index clamps
    s = rep_s(32'd100); s[2*SW +: SW] = 32'd300; s[5*SW +: SW] = 32'd300; b = rep_b('0);
    vt[1] = '{4'd12, s, b, 3, 0, 4'd9, 4'd2, 32'd300, 4'd5, 32'd0};
    // positive saturation, res_ready high on entry
    s = rep_s('0); s[4*SW +: SW] = 32'h7FFF_FFF0; b = rep_b('0); b[4*DW +: DW] = 16'h0100;
    vt[2] = '{4'd0, s, b, 1, -1, 4'd0, 4'd4, 32'h7FFF_FFFF, 4'd0, 32'h7FFF_FFFF};
    // negative scores, bias decides
    s = rep_s(32'hFFFF_FC18); b = rep_b('0); b[9*DW +: DW] = 16'd5;
    vt[3] = '{4'd5, s, b, 5, 0, 4'd5, 4'd9, 32'hFFFF_FC1D, 4'd0, 32'd5};
    // negative saturation on all but class 6
    s = rep_s(32'h8000_0010); b = rep_b(16'hFF00); b[6*DW +: DW] = '0;
    vt[4] = '{4'd9, s, b, 2, 0, 4'd9, 4'd6, 32'h8000_0010, 4'd0, 32'd16};
    // bias-only tie between 1 and 8
    s = rep_s('0); b = rep_b('0); b[1*DW +: DW] = 16'h7FFF; b[8*DW +: DW] = 16'h7FFF;
    vt[5] = '{4'd1, s, b, 1, 0, 4'd1, 4'd1, 32'h0000_7FFF, 4'd8, 32'd0};
    // runner-up: 9,7,7
    s = rep_s('0); s[0 +: SW] = 32'd9; s[SW +: SW] = 32'd7; s[2*SW +: SW] = 32'd7; b = rep_b('0);
    vt[6] = '{4'd2, s, b, 2, 0, 4'd2, 4'd0, 32'd9, 4'd1, 32'd2};
`ifdef MNIST_CLS_TOP2_EN
    nv = 7;
`else
    nv = 6;
`endif

    rst_n = 1'b0;
    m.req_valid = 0; m.req_img = '0; m.comp_ready = 0; m.scores = '0; m.bias = '0; m.res_ready = 0;
    t.req_valid = 0; t.req_img = '0; t.comp_ready = 0; t.scores = '0; t.bias = '0; t.res_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", m.req_ready, 1);
    chk("rst_res_valid", m.res_valid, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_comp_start", m.comp_start, 0);
    chk("rst_err", m.err_timeout, 0);
    chk("rst_res_score", m.res_score, 0);
    chk("rst_img_sel", m.img_sel, 0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) run_vec(i);

    // comp_ready already high at launch: no capture until a fresh rise
    @(negedge clk);
    m.scores = vt[0].sc; m.bias = vt[0].bs; m.comp_ready = 1'b1;
    m.req_img = 4'd1; m.req_valid = 1'b1;
    @(negedge clk);
    m.req_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("level_no_result", m.res_valid, 0);
    chk("level_busy", m.busy, 1);
    m.comp_ready = 1'b0;
    @(negedge clk);
    m.comp_ready = 1'b1;
    k = 0;
    while (!m.res_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("level_latency", k, NC);
    chk("level_class", m.res_class, 7);
    m.res_ready = 1'b1;
    @(negedge clk);
    m.res_ready = 1'b0; m.comp_ready = 1'b0;

    // reset while waiting on the fetcher
    m.req_valid = 1'b1;
    @(negedge clk);
    m.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", m.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_req_ready", m.req_ready, 1);
    chk("midrun_rst_busy", m.busy, 0);
    chk("midrun_rst_res_valid", m.res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // timeout on the TIMEOUT=16 instance
    @(negedge clk);
    t.req_valid = 1'b1;
    @(negedge clk);
    t.req_valid = 1'b0;
    chk("to_comp_start", t.comp_start, 1);
    k = 0;
    while (!t.err_timeout && k < 40) begin
      @(negedge clk);
      k++;
      if (t.res_valid) chk("to_res_valid", t.res_valid, 0);
    end
    chk("to_cycles", k, 16);
    chk("to_idle", t.req_ready, 1);
    chk("to_busy", t.busy, 0);
    repeat (2) @(negedge clk);
    chk("to_sticky", t.err_timeout, 1);
    t.req_valid = 1'b1;
    @(negedge clk);
    t.req_valid = 1'b0;
    chk("to_clear", t.err_timeout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
